// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: FU result packet, broadcast packet and default FU count.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_W
`define ROB_TAG_W 5
`endif

package cdb_arbiter_pkg;

   localparam int unsigned NUM_FU = 4;

   typedef struct packed {
      logic                  done;
      logic [`XLEN-1:0]      v;
      logic [`ROB_TAG_W-1:0] rob_tag;
   } FU_CDB_PACKET;

   typedef struct packed {
      logic                  valid;
      logic [`XLEN-1:0]      v;
      logic [`ROB_TAG_W-1:0] rob_tag;
   } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin request-to-one-hot arbiter; owns the rotating priority pointer.
module rr_arbiter #(
   parameter int unsigned NUM_FU = 4,
   parameter int unsigned IDX_W  = $clog2(NUM_FU)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_FU-1:0] req_i,
   input  logic              hold_i,
   output logic [NUM_FU-1:0] grant_o,
   output logic [IDX_W-1:0]  grant_idx_o,
   output logic              grant_vld_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int unsigned      pos;

   // Scan from ptr_q upward with wrap; the first request seen wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      ptr_d       = ptr_q;
      pos         = 0;
      if (!reset && !hold_i) begin
         for (int unsigned k = 0; k < NUM_FU; k++) begin
            pos = (32'(ptr_q) + k) % NUM_FU;
            if (!grant_vld_o && req_i[IDX_W'(pos)]) begin
               grant_vld_o              = 1'b1;
               grant_idx_o              = IDX_W'(pos);
               grant_o[IDX_W'(pos)]     = 1'b1;
               ptr_d                    = (pos == NUM_FU - 1) ? '0 : IDX_W'(pos + 1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// FU->CDB arbiter: round-robin grant, single-cycle ack, registered CDB broadcast.
// Optional per-FU saturating grant counters with CDB_GRANT_COUNT_EN.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = cdb_arbiter_pkg::NUM_FU,
   parameter int unsigned IDX_W  = $clog2(NUM_FU)
) (
   input  logic              clock,
   input  logic              reset,
   input  FU_CDB_PACKET      fu_pkts [NUM_FU],
   input  logic              squash,
   output logic [NUM_FU-1:0] ack,
   output CDB_PACKET         cdb_pkt
`ifdef CDB_GRANT_COUNT_EN
  ,output logic [15:0]       grant_cnt [NUM_FU]
`endif
);

   logic [NUM_FU-1:0] req;
   logic [NUM_FU-1:0] grant;
   logic [IDX_W-1:0]  gidx;
   logic              gvld;
   CDB_PACKET         cdb_q, cdb_d;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) req[i] = fu_pkts[i].done;
   end

   rr_arbiter #(
      .NUM_FU (NUM_FU),
      .IDX_W  (IDX_W)
   ) u_rr (
      .clock       (clock),
      .reset       (reset),
      .req_i       (req),
      .hold_i      (squash),
      .grant_o     (grant),
      .grant_idx_o (gidx),
      .grant_vld_o (gvld)
   );

   assign ack = grant;

   // Payload holds its last value when idle; only valid is meaningful then.
   always_comb begin
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      if (gvld) begin
         cdb_d.valid   = 1'b1;
         cdb_d.v       = fu_pkts[gidx].v;
         cdb_d.rob_tag = fu_pkts[gidx].rob_tag;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) cdb_q <= '0;
      else       cdb_q <= cdb_d;
   end

   assign cdb_pkt = cdb_q;

`ifdef CDB_GRANT_COUNT_EN
   logic [15:0] cnt_q [NUM_FU];

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (reset)                            cnt_q[i] <= '0;
         else if (grant[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then randomized run against a
// queue-free round-robin reference model. Counter checks with CDB_GRANT_COUNT_EN.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         squash = 1'b0;
   FU_CDB_PACKET fu_pkts [N];
   logic [N-1:0] ack;
   CDB_PACKET    cdb_pkt;
`ifdef CDB_GRANT_COUNT_EN
   logic [15:0]  grant_cnt [N];
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clock     (clock),
      .reset     (reset),
      .fu_pkts   (fu_pkts),
      .squash    (squash),
      .ack       (ack),
      .cdb_pkt   (cdb_pkt)
`ifdef CDB_GRANT_COUNT_EN
     ,.grant_cnt (grant_cnt)
`endif
   );

   typedef struct {
      logic             rst;
      logic             sq;
      logic [N-1:0]     done;
      logic [N-1:0]     ack;
      logic             vld;
      logic             chk;
      logic [`XLEN-1:0] v;
      logic [`ROB_TAG_W-1:0] tag;
   } vec_t;

   vec_t tbl [22];
   logic [`XLEN-1:0]      vtab [N];
   logic [`ROB_TAG_W-1:0] ttab [N];

   function automatic vec_t mk(logic rst, logic sq, logic [N-1:0] d, logic [N-1:0] a,
                               logic vl, logic c, logic [`XLEN-1:0] v, logic [`ROB_TAG_W-1:0] t);
      vec_t r;
      r.rst = rst; r.sq = sq; r.done = d; r.ack = a; r.vld = vl; r.chk = c; r.v = v; r.tag = t;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are applied before the negedge; ack sampled there, cdb just after posedge.
   task automatic tick(output logic [N-1:0] a, output CDB_PACKET c);
      @(negedge clock);
      a = ack;
      @(posedge clock);
      #1;
      c = cdb_pkt;
   endtask

   // Reference model state for the randomized phase
   int               m_ptr;
   logic             m_done [N];
   logic [`XLEN-1:0] m_v    [N];
   logic [`ROB_TAG_W-1:0] m_tag [N];
   int               m_wait [N];
   int unsigned      m_cnt  [N];

   initial begin
      logic [N-1:0] a;
      CDB_PACKET    c;
      int           w;
      logic         rst, sq;

      vtab = '{32'h0000_000A, 32'h0000_000B, 32'h0000_0015, 32'h0000_000D};
      ttab = '{5'd1, 5'd3, 5'd5, 5'd7};

      //            rst  sq  done     ack      vld chk v      tag
      tbl[0]  = mk(1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,32'h00,5'd0);
      tbl[1]  = mk(1'b0,1'b0,4'b1111,4'b0001,1'b1,1'b1,32'h0A,5'd1);
      tbl[2]  = mk(1'b0,1'b0,4'b1110,4'b0010,1'b1,1'b1,32'h0B,5'd3);
      tbl[3]  = mk(1'b0,1'b0,4'b1100,4'b0100,1'b1,1'b1,32'h15,5'd5);
      tbl[4]  = mk(1'b0,1'b0,4'b1000,4'b1000,1'b1,1'b1,32'h0D,5'd7);
      tbl[5]  = mk(1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,32'h00,5'd0);
      tbl[6]  = mk(1'b0,1'b0,4'b0100,4'b0100,1'b1,1'b1,32'h15,5'd5);
      tbl[7]  = mk(1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,32'h00,5'd0);
      tbl[8]  = mk(1'b0,1'b0,4'b1001,4'b1000,1'b1,1'b1,32'h0D,5'd7);
      tbl[9]  = mk(1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b1,32'h0A,5'd1);
      tbl[10] = mk(1'b0,1'b1,4'b0010,4'b0000,1'b0,1'b0,32'h00,5'd0);
      tbl[11] = mk(1'b0,1'b0,4'b0010,4'b0010,1'b1,1'b1,32'h0B,5'd3);
      tbl[12] = mk(1'b0,1'b1,4'b0100,4'b0000,1'b0,1'b0,32'h00,5'd0);
      tbl[13] = mk(1'b0,1'b0,4'b0100,4'b0100,1'b1,1'b1,32'h15,5'd5);
      tbl[14] = mk(1'b0,1'b0,4'b0010,4'b0010,1'b1,1'b1,32'h0B,5'd3);
      tbl[15] = mk(1'b1,1'b1,4'b1000,4'b0000,1'b0,1'b1,32'h00,5'd0);
      tbl[16] = mk(1'b0,1'b0,4'b1000,4'b1000,1'b1,1'b1,32'h0D,5'd7);
      tbl[17] = mk(1'b0,1'b0,4'b0110,4'b0010,1'b1,1'b1,32'h0B,5'd3);
      tbl[18] = mk(1'b0,1'b0,4'b0100,4'b0100,1'b1,1'b1,32'h15,5'd5);
      tbl[19] = mk(1'b0,1'b0,4'b0010,4'b0010,1'b1,1'b1,32'h0B,5'd3);
      tbl[20] = mk(1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,32'h00,5'd0);
      tbl[21] = mk(1'b0,1'b0,4'b1010,4'b0010,1'b1,1'b1,32'h0B,5'd3);

      for (int i = 0; i < N; i++) fu_pkts[i] = '{done: 1'b0, v: vtab[i], rob_tag: ttab[i]};
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      for (int r = 0; r < 22; r++) begin
         reset  = tbl[r].rst;
         squash = tbl[r].sq;
         for (int i = 0; i < N; i++) fu_pkts[i] = '{done: tbl[r].done[i], v: vtab[i], rob_tag: ttab[i]};
         tick(a, c);
         chk($sformatf("vec%0d_ack", r), 64'(a), 64'(tbl[r].ack));
         chk($sformatf("vec%0d_valid", r), 64'(c.valid), 64'(tbl[r].vld));
         if (tbl[r].chk) begin
            chk($sformatf("vec%0d_v", r), 64'(c.v), 64'(tbl[r].v));
            chk($sformatf("vec%0d_tag", r), 64'(c.rob_tag), 64'(tbl[r].tag));
         end
      end

      // Randomized phase: FUs raise done with fresh data and drop it only when acked.
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         m_done[i] = 1'b0; m_v[i] = '0; m_tag[i] = '0; m_wait[i] = 0; m_cnt[i] = 0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = (cyc == 0) || ($urandom_range(99) < 3);
         sq  = ($urandom_range(99) < 10);
         for (int i = 0; i < N; i++) begin
            if (!m_done[i] && $urandom_range(99) < 40) begin
               m_done[i] = 1'b1;
               m_v[i]    = $urandom;
               m_tag[i]  = $urandom;
            end
            fu_pkts[i] = '{done: m_done[i], v: m_v[i], rob_tag: m_tag[i]};
         end
         reset  = rst;
         squash = sq;

         w = -1;
         if (!rst && !sq) begin
            for (int k = 0; k < N; k++) begin
               if (w < 0 && m_done[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
         end

         tick(a, c);
         chk("rnd_ack", 64'(a), (w < 0) ? 64'd0 : (64'd1 << w));
         chk("rnd_valid", 64'(c.valid), 64'(w >= 0));
         if (w >= 0) begin
            chk("rnd_v", 64'(c.v), 64'(m_v[w]));
            chk("rnd_tag", 64'(c.rob_tag), 64'(m_tag[w]));
         end else if (rst) begin
            chk("rnd_rst_data", {31'd0, c.v, c.rob_tag}, 64'd0);
         end

         if (rst) begin
            m_ptr = 0;
            for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_wait[i] = 0; end
         end else if (!sq) begin
            for (int i = 0; i < N; i++) if (m_done[i]) m_wait[i]++;
         end
         if (w >= 0) begin
            chk("rnd_fair", 64'(m_wait[w] <= N), 64'd1);
            m_done[w] = 1'b0;
            m_wait[w] = 0;
            m_ptr     = (w + 1) % N;
            if (m_cnt[w] < 16'hFFFF) m_cnt[w]++;
         end
      end

`ifdef CDB_GRANT_COUNT_EN
      for (int i = 0; i < N; i++) chk($sformatf("rnd_cnt%0d", i), 64'(grant_cnt[i]), 64'(m_cnt[i]));

      reset  = 1'b1;
      squash = 1'b0;
      for (int i = 0; i < N; i++) fu_pkts[i] = '{done: 1'b0, v: vtab[i], rob_tag: ttab[i]};
      @(posedge clock); #1;
      reset = 1'b0;
      fu_pkts[0].done = 1'b1;
      repeat (70000) @(posedge clock);
      #1;
      fu_pkts[0].done = 1'b0;
      chk("sat_cnt0", 64'(grant_cnt[0]), 64'hFFFF);
      for (int i = 1; i < N; i++) chk($sformatf("sat_cnt%0d", i), 64'(grant_cnt[i]), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
